// File: rtl/tpu_pkg.sv
// Shared constants and the transfer FSM state type, used by the operand
// feeder and the future result drain of the tpumac systolic array.
package tpu_pkg;

    localparam int BITS_AB_DEF = 8;
    localparam int DIM_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One skew lane: an enable-gated shift chain of DEPTH stages.
// The chain only moves on advance cycles, so a stall freezes the lane.
module skew_lane #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else if (en) begin
            stage_q[0] <= din;
            for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder that re-times DIM-lane vectors into a diagonal wavefront.
// Optional stall counter output is enabled by defining FEEDER_STALL_CNT_EN.
module systolic_skew_feeder
    import tpu_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int DIM     = DIM_DEF,
    parameter int LEN_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIM*BITS_AB-1:0] in_data,
    output logic [DIM*BITS_AB-1:0] out_data,
    output logic                   out_en,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    localparam int DW = (DIM > 2) ? $clog2(DIM) : 1;

    xfer_state_e            state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       accCnt_q, accCnt_d;
    logic [DW-1:0]          drainCnt_q, drainCnt_d;
    logic                   outEn_q, done_q;
    logic                   advance;
    logic [DIM*BITS_AB-1:0] laneIn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            accCnt_q   <= '0;
            drainCnt_q <= '0;
            outEn_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            accCnt_q   <= accCnt_d;
            drainCnt_q <= drainCnt_d;
            outEn_q    <= advance;
            done_q     <= (state_q == DONE);
        end
    end

    // Drain feeds zeros so the last vector walks out of the deepest lane.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        accCnt_d   = accCnt_q;
        drainCnt_d = drainCnt_q;
        advance    = 1'b0;
        laneIn     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = len;
                    accCnt_d   = '0;
                    drainCnt_d = '0;
                    state_d    = (len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (in_valid) begin
                    advance  = 1'b1;
                    laneIn   = in_data;
                    accCnt_d = accCnt_q + 1'b1;
                    if (accCnt_q == len_q - 1'b1) state_d = (DIM > 1) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                advance    = 1'b1;
                drainCnt_d = drainCnt_q + 1'b1;
                if (drainCnt_q == DW'(DIM - 2)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < DIM; i++) begin : gLane
        skew_lane #(
            .W     (BITS_AB),
            .DEPTH (i + 1)
        ) uLane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (advance),
            .din   (laneIn[i*BITS_AB +: BITS_AB]),
            .dout  (out_data[i*BITS_AB +: BITS_AB])
        );
    end

    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign out_en   = outEn_q;
    assign done     = done_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == STREAM && !in_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Operand transmitter for the tpumac systolic array. It accepts one DIM-lane operand vector per handshake and re-times it into a diagonal wavefront. Lane i is delayed i advance-steps, then driven onto the Ain (or Bin) edge of the array together with the array enable. After the last vector it flushes zeros so every MAC column completes its accumulation, then signals done.

Parameters:
BITS_AB, 8, width of one signed operand lane (matches the MAC A/B width)
DIM, 8, array dimension; number of lanes; maximum skew is DIM-1
LEN_W, 16, width of the vector-count input

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a transfer; sampled only in IDLE
len  input  LEN_W  number of vectors in the transfer; latched on start
in_valid  input  1  in_data holds a vector
in_ready  output  1  feeder accepts a vector this cycle
in_data  input  DIM*BITS_AB  lane i at bits [i*BITS_AB +: BITS_AB], signed
out_data  output  DIM*BITS_AB  skewed lanes to the array edge, same packing
out_en  output  1  array enable; drives en of every tpumac
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse when the transfer is complete

Behaviour:
- Reset (async, mid-operation included): state=IDLE; all skew registers, out_data, out_en, done, counters = 0; in_ready=0.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: start=1 latches len. len>0 -> STREAM. len=0 -> DONE directly. start is ignored in every other state.
- STREAM: in_ready=1. Accept = in_valid&in_ready. On accept, the vector is shifted into the skew structure and the accept count increments. Accepting the len-th vector -> DRAIN (in_ready drops the next cycle).
- Stall: a STREAM cycle with no accept does not advance the skew registers and gives out_en=0 on the next cycle. The array holds, matching tpumac en semantics.
- DRAIN: exactly DIM-1 advance cycles, each shifting an all-zero vector into the skew structure. in_ready=0. Then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- Skew structure: lane i is a shift chain of depth i+1 that advances only on an advance cycle (accept or drain). Lane 0 is a single register. out_data lane i = last stage of chain i.
- Registered outputs: out_en(t+1) = advance(t).
  - A vector accepted at cycle t appears on lane 0 at t+1.
  - Because chains advance only on advance cycles, lane i shows it i advances later (i cycles later when there are no stalls).
- Total out_en=1 cycles per transfer = len+DIM-1 (0 when len=0).
- out_data holds its value while out_en=0.
- Zeros enter lanes ahead of the first vector (from reset/previous drain). Zero operands add 0 to Cout, so the leading edge of the wavefront is harmless.
- Arithmetic: none. Data are passed bit-exact; sign is preserved.
- The accept counter is LEN_W bits wide. len=2^LEN_W-1 must complete without wrap.

Optional Feature:
Macro FEEDER_STALL_CNT_EN.
- Defined: adds output stall_cycles [15:0]. It counts STREAM cycles with in_valid=0, saturates at 16'hFFFF, clears on an accepted start and on reset, and holds its value after done.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package tpu_pkg holds: the BITS_AB/DIM default constants and the FSM state typedef (IDLE, STREAM, DRAIN, DONE), so the feeder and a future result drain share them.
- One natural sub-module, skew_lane: a parameterised-depth, enable-gated shift register. It is instantiated DIM times via generate, with depth i+1.

Test Plan:
- DIM=4, len=3, vectors {lanes 0..3} = {1,2,3,4},{5,6,7,8},{9,10,11,12}, in_valid held high:
  - out_en high exactly 6 consecutive cycles starting 1 cycle after the first accept.
  - lane0 sequence 1,5,9,0,0,0; lane3 sequence 0,0,0,4,8,12.
  - done pulses the cycle after the last out_en.
- Same data with in_valid=0 for 2 cycles between vectors 1 and 2: out_en has a 2-cycle gap, out_data is frozen during the gap, and the lane sequences are unchanged.
- len=0 with start: busy high 1 cycle; done pulses; out_en never asserts.
- Signed data lanes = -128,127,-1,0: values appear bit-exact, skewed by 0..3 cycles.
- rst_n low mid-STREAM after 1 of 3 vectors: all outputs 0 immediately and state IDLE. A subsequent start with len=1 completes normally with 4 out_en cycles.
- With FEEDER_STALL_CNT_EN, 5 stall cycles in a transfer: stall_cycles=5 after done; the next start clears it to 0.
